// File: rtl/reg_writeback_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
package reg_writeback_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_REG_NUM    = 32;
  localparam int WB_AW         = $clog2(WB_REG_NUM);
  localparam int WB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [WB_AW-1:0]         addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // Address width for a register count, never below one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with occupancy output for buffered ALU results.
// REG_WRITEBACK_BYPASS_EN exposes all entries, oldest first, for address lookup.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH = WB_AW + WB_DATA_WIDTH,
  parameter int DEPTH = WB_FIFO_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LW-1:0]    level_o
`ifdef REG_WRITEBACK_BYPASS_EN
  ,
  output logic [DEPTH-1:0][WIDTH-1:0] ent_o,
  output logic [DEPTH-1:0]            ent_vld_o
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wptr_q, rptr_q;
  logic [LW-1:0]               level_q, level_d;
  logic                        push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign head_o  = mem_q[rptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) level_d = level_q + LW'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

`ifdef REG_WRITEBACK_BYPASS_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_o[i]     = mem_q[rptr_q + PW'(i)];
      ent_vld_o[i] = (LW'(i) < level_q);
    end
  end
`endif

endmodule

// File: rtl/reg_writeback.sv
// Write-back arbiter: loads win the register-file port, ALU results queue in wb_fifo.
// REG_WRITEBACK_BYPASS_EN adds a registered forwarding lookup (byp_addr/byp_hit/byp_data).
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int REG_NUM    = WB_REG_NUM,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  localparam int AW = addr_width(REG_NUM),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [AW-1:0]         alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_wren,
  output logic [LW-1:0]         fifo_level
`ifdef REG_WRITEBACK_BYPASS_EN
  ,
  input  logic [AW-1:0]         byp_addr,
  output logic                  byp_hit,
  output logic [DATA_WIDTH-1:0] byp_data
`endif
);

  localparam int EW = AW + DATA_WIDTH;

  logic [EW-1:0]         head;
  logic                  empty, full, push, pop;
  logic [AW-1:0]         head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [AW-1:0]         rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_wren_q;

`ifdef REG_WRITEBACK_BYPASS_EN
  logic [FIFO_DEPTH-1:0][EW-1:0] ent;
  logic [FIFO_DEPTH-1:0]         ent_vld;
`endif

  assign ld_ready  = 1'b1;
  assign alu_ready = !full;
  assign push      = alu_valid && !full;
  assign pop       = !ld_valid && !empty;

  assign head_addr = head[EW-1 -: AW];
  assign head_data = head[DATA_WIDTH-1:0];

  wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({alu_addr, alu_data}),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .level_o (fifo_level)
`ifdef REG_WRITEBACK_BYPASS_EN
    ,
    .ent_o     (ent),
    .ent_vld_o (ent_vld)
`endif
  );

  // x0 results still occupy the port for a cycle but never assert the write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_wren_q <= 1'b0;
    end else if (ld_valid) begin
      rd_addr_q <= ld_addr;
      rd_data_q <= ld_data;
      rd_wren_q <= (ld_addr != '0);
    end else if (!empty) begin
      rd_addr_q <= head_addr;
      rd_data_q <= head_data;
      rd_wren_q <= (head_addr != '0);
    end else begin
      rd_wren_q <= 1'b0;
    end
  end

  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
  assign rd_wren = rd_wren_q;

`ifdef REG_WRITEBACK_BYPASS_EN
  logic                  byp_hit_d, byp_hit_q;
  logic [DATA_WIDTH-1:0] byp_data_d, byp_data_q;

  // Scan oldest to newest so later matches override; the rd stage is newest of all.
  always_comb begin
    byp_hit_d  = 1'b0;
    byp_data_d = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i] && ent[i][EW-1 -: AW] == byp_addr) begin
        byp_hit_d  = 1'b1;
        byp_data_d = ent[i][DATA_WIDTH-1:0];
      end
    end
    if (rd_wren_q && rd_addr_q == byp_addr) begin
      byp_hit_d  = 1'b1;
      byp_data_d = rd_data_q;
    end
    if (byp_addr == '0) begin
      byp_hit_d  = 1'b0;
      byp_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign byp_hit  = byp_hit_q;
  assign byp_data = byp_data_q;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with default parameters.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0, ld_ready;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        alu_valid = 1'b0, alu_ready;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wren;
  logic [2:0]  fifo_level;
`ifdef REG_WRITEBACK_BYPASS_EN
  logic [4:0]  byp_addr = '0;
  logic        byp_hit;
  logic [31:0] byp_data;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wren(rd_wren), .fifo_level(fifo_level)
`ifdef REG_WRITEBACK_BYPASS_EN
    , .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (rd_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%0h exp=0", rd_wren); end
    checks++; if (rd_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", rd_addr); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", rd_data); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b%b exp=11", alu_ready, ld_ready); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    checks++; if (rd_wren !== 1'b0 || fifo_level !== 3'd1) begin failures++; $display("FAIL alu_e wren/level got=%b/%0d exp=0/1", rd_wren, fifo_level); end
    tick();
    checks++; if (rd_wren !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_write got=%b %0d %h exp=1 5 deadbeef", rd_wren, rd_addr, rd_data); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL alu_level got=%0d exp=0", fifo_level); end
    tick();
    checks++; if (rd_wren !== 1'b0 || rd_addr !== 5'd5) begin failures++; $display("FAIL alu_one_cycle got=%b %0d exp=0 5", rd_wren, rd_addr); end
  endtask

  task automatic test_simultaneous();
    ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h22;
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    checks++; if (rd_wren !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h11 || fifo_level !== 3'd1) begin failures++; $display("FAIL sim_load got=%b %0d %h lvl=%0d exp=1 3 11 lvl=1", rd_wren, rd_addr, rd_data, fifo_level); end
    tick();
    checks++; if (rd_wren !== 1'b1 || rd_addr !== 5'd4 || rd_data !== 32'h22 || fifo_level !== 3'd0) begin failures++; $display("FAIL sim_alu got=%b %0d %h lvl=%0d exp=1 4 22 lvl=0", rd_wren, rd_addr, rd_data, fifo_level); end
    tick();
    checks++; if (rd_wren !== 1'b0) begin failures++; $display("FAIL sim_idle got=%b exp=0", rd_wren); end
  endtask

  task automatic test_starve();
    int n = 0;
    logic acc;
    ld_valid = 1'b1; ld_addr = 5'd1;
    alu_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      acc = alu_ready;
      ld_data = 32'h100 + 32'(c);
      alu_addr = 5'(10 + n); alu_data = 32'hA0 + 32'(n);
      tick();
      if (acc) n++;
      checks++; if (rd_wren !== 1'b1 || rd_data !== 32'h100 + 32'(c)) begin failures++; $display("FAIL starve_load%0d got=%b %h exp=1 %h", c, rd_wren, rd_data, 32'h100 + 32'(c)); end
      checks++; if (alu_ready !== (c < 3)) begin failures++; $display("FAIL starve_ready%0d got=%b exp=%b", c, alu_ready, c < 3); end
    end
    checks++; if (n != 4 || fifo_level !== 3'(WB_FIFO_DEPTH)) begin failures++; $display("FAIL starve_accepts got=%0d lvl=%0d exp=4 lvl=4", n, fifo_level); end
    ld_valid = 1'b0;
    alu_addr = 5'd14; alu_data = 32'hA4;
    tick();
    alu_valid = 1'b0;
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL full_no_push got=%0d exp=3", fifo_level); end
    checks++; if (rd_wren !== 1'b1 || rd_addr !== 5'd10 || rd_data !== 32'hA0) begin failures++; $display("FAIL drain0 got=%b %0d %h exp=1 10 a0", rd_wren, rd_addr, rd_data); end
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++; if (rd_wren !== 1'b1 || rd_addr !== 5'(10 + i) || rd_data !== 32'hA0 + 32'(i)) begin failures++; $display("FAIL drain%0d got=%b %0d %h exp=1 %0d %h", i, rd_wren, rd_addr, rd_data, 10 + i, 32'hA0 + 32'(i)); end
    end
    tick();
    checks++; if (rd_wren !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL drain_end got=%b %0d exp=0 0", rd_wren, fifo_level); end
  endtask

  task automatic test_x0();
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", alu_ready); end
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
    tick();
    alu_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1 || rd_wren !== 1'b0) begin failures++; $display("FAIL x0_accept lvl=%0d wren=%b exp=1 0", fifo_level, rd_wren); end
    tick();
    checks++; if (fifo_level !== 3'd0 || rd_wren !== 1'b0 || rd_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL x0_pop lvl=%0d wren=%b data=%h exp=0 0 ffffffff", fifo_level, rd_wren, rd_data); end
    tick();
    checks++; if (rd_wren !== 1'b0) begin failures++; $display("FAIL x0_after got=%b exp=0", rd_wren); end
  endtask

  task automatic test_reset_mid();
    ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 32'h77;
    alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_addr = 5'(20 + i); alu_data = 32'hC0 + 32'(i);
      tick();
    end
    alu_valid = 1'b0;
    checks++; if (fifo_level !== 3'd3 || rd_wren !== 1'b1) begin failures++; $display("FAIL mid_fill lvl=%0d wren=%b exp=3 1", fifo_level, rd_wren); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rd_wren !== 1'b0 || fifo_level !== 3'd0 || rd_addr !== 5'd0 || alu_ready !== 1'b1) begin failures++; $display("FAIL mid_async wren=%b lvl=%0d addr=%0d rdy=%b exp=0 0 0 1", rd_wren, fifo_level, rd_addr, alu_ready); end
    ld_valid = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_wren !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL mid_stale%0d wren=%b lvl=%0d exp=0 0", i, rd_wren, fifo_level); end
    end
  endtask

`ifdef REG_WRITEBACK_BYPASS_EN
  task automatic test_bypass();
    ld_valid = 1'b1; ld_addr = 5'd1; ld_data = 32'h55;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hA;
    tick();
    alu_data = 32'hB;
    tick();
    alu_valid = 1'b0;
    byp_addr = 5'd7;
    tick();
    checks++; if (byp_hit !== 1'b1 || byp_data !== 32'hB) begin failures++; $display("FAIL byp_newest hit=%b data=%h exp=1 b", byp_hit, byp_data); end
    byp_addr = 5'd1;
    tick();
    checks++; if (byp_hit !== 1'b1 || byp_data !== 32'h55) begin failures++; $display("FAIL byp_rd hit=%b data=%h exp=1 55", byp_hit, byp_data); end
    byp_addr = 5'd0;
    tick();
    checks++; if (byp_hit !== 1'b0) begin failures++; $display("FAIL byp_x0 hit=%b exp=0", byp_hit); end
    ld_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (fifo_level !== 3'd0 || rd_wren !== 1'b0) begin failures++; $display("FAIL byp_drain lvl=%0d wren=%b exp=0 0", fifo_level, rd_wren); end
  endtask
`endif

  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_starve();
    test_x0();
    test_reset_mid();
`ifdef REG_WRITEBACK_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back arbiter for the integer register file's single write port (`rd_addr`/`rd_data`/`rd_wren`). It accepts results from two producers, the load unit and the ALU, each over a valid/ready handshake. It serializes them onto the one write port: loads take priority, and ALU results are buffered in a small FIFO. Writes targeting register 0 are consumed and never issued, consistent with the register file's hardwired-zero x0.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width
- `REG_NUM`, 32, number of registers; address width `AW = clog2(REG_NUM)`
- `FIFO_DEPTH`, 4, ALU result buffer entries; power of two, ≥2

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ld_valid`  in  1  load result valid
- `ld_ready`  out  1  tied high: a load is always accepted
- `ld_addr`  in  AW  destination register
- `ld_data`  in  DATA_WIDTH  load result
- `alu_valid`  in  1  ALU result valid
- `alu_ready`  out  1  ALU FIFO can accept
- `alu_addr`  in  AW  destination register
- `alu_data`  in  DATA_WIDTH  ALU result
- `rd_addr`  out  AW  register-file write address
- `rd_data`  out  DATA_WIDTH  register-file write data
- `rd_wren`  out  1  register-file write enable
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  current ALU FIFO occupancy

## Operation
- Handshake: a transfer occurs on a rising edge where `valid && ready` are both high. A producer holds `addr`/`data` stable while `valid` is high and `ready` is low.
- `alu_ready = (fifo_level != FIFO_DEPTH)`, taken from the registered count. No push is allowed when full, even if a pop occurs in the same cycle.
- Issue stage, evaluated each edge:
  - if `ld_valid`: issue the load.
  - else if the FIFO is non-empty: pop the head and issue it.
  - else: issue nothing.
- Issuing means `rd_addr`/`rd_data` are registered from the source, and `rd_wren` is registered as `(addr != 0)`.
- When nothing is issued, `rd_wren` is registered 0 and `rd_addr`/`rd_data` hold their previous values.
- Ordering: ALU results reach the register file in acceptance order. Load vs ALU ordering to the same register is the producer's responsibility.
- Push and pop on the same edge: `fifo_level` is unchanged. Read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset (`rst` low, asynchronous): `rd_wren=0`, `rd_addr=0`, `rd_data=0`, FIFO pointers 0, `fifo_level=0`, `alu_ready=1`, `ld_ready=1`. Any buffered ALU results are discarded.
- Load latency: a load accepted at edge E produces `rd_wren` high during the cycle following E.
- ALU latency: an ALU result accepted at edge E becomes the FIFO head after E. With no load present, `rd_wren` is high during the cycle following E+1, giving 2-cycle latency.
- Sustained loads starve the FIFO. `alu_ready` falls in the cycle after the FIFO's level reaches `FIFO_DEPTH`.
- Throughput: one write per cycle maximum.

## Configuration
- `REG_WRITEBACK_BYPASS_EN` defined adds ports `byp_addr` (in, AW), `byp_hit` (out, 1) and `byp_data` (out, DATA_WIDTH).
  - Outputs are registered, one-cycle latency, matching the register file's synchronous read.
  - `byp_hit=1` when the address equals `rd_addr` with `rd_wren` high, or matches any valid FIFO entry. Newest data wins, in this priority: the `rd_*` stage, then the FIFO tail toward the head.
  - Address 0 never hits. Reset value: `byp_hit=0`, `byp_data=0`.
- Macro undefined: the bypass ports and logic are absent, and all other behaviour is identical.

## Structure
- Shared package `reg_writeback_pkg`:
  - the `wb_entry_t` struct {addr, data}
  - address-width constant derived from `REG_NUM`
  - default `FIFO_DEPTH`
- One sub-module, `wb_fifo`: a parameterized synchronous FIFO with level output and asynchronous active-low reset. Arbitration, the x0 filter and the bypass stay in the top level.

## Test plan
- Reset mid-operation: fill the FIFO with 3 entries, then pulse `rst` low → `rd_wren=0` immediately, `fifo_level=0`, and no stale writes after release.
- Single ALU write (addr 5, data 0xDEADBEEF) at edge E → during the cycle after E+1: `rd_wren=1`, `rd_addr=5`, `rd_data=0xDEADBEEF`, for exactly one cycle.
- Simultaneous load (addr 3, 0x11) and ALU (addr 4, 0x22) at edge E:
  - load written in the cycle after E;
  - ALU written in the following cycle;
  - `fifo_level` reads 1 during the first of these cycles and 0 during the second.
- Hold `ld_valid` high for 6 cycles while driving `alu_valid` continuously → `alu_ready` drops after 4 accepts. Once loads stop, the 4 ALU writes drain in order, one per cycle.
- Write to x0: ALU addr 0, data 0xFFFFFFFF → handshake completes, FIFO pops, and `rd_wren` never rises.
- With `REG_WRITEBACK_BYPASS_EN`, two ALU results to addr 7 (0xA then 0xB) are buffered while loads stall the port. A bypass lookup of addr 7 → `byp_hit=1`, `byp_data=0xB` one cycle later. A lookup of addr 0 → `byp_hit=0`.
